serial_bcd_converter: RTL and testbench

//  Multi-cycle shift-and-add-3 (double-dabble) binary-to-BCD converter feeding the 7-segment display stage.

---
 rtl/serial_bcd_converter_if.sv | 25 ++
 rtl/serial_bcd_converter.sv | 98 +++++++++
 tb/tb_serial_bcd_converter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_bcd_converter_if.sv
// Request/result bundle between a requester and the serial binary-to-BCD converter.
// The requester drives start/binary; the converter returns status, four digits and overflow.
interface serial_bcd_converter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] binary;
  logic             busy;
  logic             done;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [3:0]       thousands;
  logic             overflow;

  modport master (
    output start, binary,
    input  busy, done, ones, tens, hundreds, thousands, overflow
  );

  modport slave (
    input  start, binary,
    output busy, done, ones, tens, hundreds, thousands, overflow
  );
endinterface

// File: rtl/serial_bcd_converter.sv
// Multi-cycle double-dabble binary-to-BCD converter: one add-3/shift layer per clock.
// The four low digits and the overflow flag are registered and only change on done,
// so the display never shows a partially converted value.
module serial_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_bcd_converter_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    bin_sr_reg;
  logic [4*DIGITS-1:0] bcd_sr_reg;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                overflow_reg;
  logic [3:0]          ones_reg;
  logic [3:0]          tens_reg;
  logic [3:0]          hundreds_reg;
  logic [3:0]          thousands_reg;

  // Add-3 correction per nibble; each nibble is independent, no carry between digits.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_sr_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_sr_reg[4*gi +: 4] + 4'd3
                                  : bcd_sr_reg[4*gi +: 4];
    end
  endgenerate

  // Control FSM with scratch shift registers and registered result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      bin_sr_reg    <= '0;
      bcd_sr_reg    <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      ones_reg      <= 4'd0;
      tens_reg      <= 4'd0;
      hundreds_reg  <= 4'd0;
      thousands_reg <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            bin_sr_reg <= bus.binary;
            bcd_sr_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          // Corrected BCD and the binary register shift together as one wide register.
          {bcd_sr_reg, bin_sr_reg} <= {bcd_adj[4*DIGITS-2:0], bin_sr_reg, 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          ones_reg      <= bcd_sr_reg[3:0];
          tens_reg      <= bcd_sr_reg[7:4];
          hundreds_reg  <= bcd_sr_reg[11:8];
          thousands_reg <= bcd_sr_reg[15:12];
          overflow_reg  <= |bcd_sr_reg[4*DIGITS-1:16];
          done_reg      <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.ones      = ones_reg;
  assign bus.tens      = tens_reg;
  assign bus.hundreds  = hundreds_reg;
  assign bus.thousands = thousands_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_serial_bcd_converter.sv
// Directed and random checks of the serial BCD converter: latency, busy/done timing,
// digit values, overflow, start-while-busy behaviour and mid-conversion reset.
module tb_serial_bcd_converter;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  serial_bcd_converter_if #(.WIDTH(32)) bus ();

  serial_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_digits(input string tag, input logic [3:0] th, input logic [3:0] h,
                              input logic [3:0] t, input logic [3:0] o, input logic ov);
    check({tag, " thousands"}, 32'(bus.thousands), 32'(th));
    check({tag, " hundreds"},  32'(bus.hundreds),  32'(h));
    check({tag, " tens"},      32'(bus.tens),      32'(t));
    check({tag, " ones"},      32'(bus.ones),      32'(o));
    check({tag, " overflow"},  32'(bus.overflow),  32'(ov));
  endtask

  // Start a conversion from IDLE, time it, and confirm done is a single-cycle pulse.
  task automatic convert(input string tag, input logic [31:0] v);
    int lat;
    int busy_cnt;
    logic hold_bad;
    logic [15:0] prev;
    prev = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    hold_bad = 1'b0;
    bus.binary = v;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.binary = 32'hDEAD_BEEF;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if ({bus.thousands, bus.hundreds, bus.tens, bus.ones} !== prev) hold_bad = 1'b1;
      tick();
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, " digits held"}, 32'(hold_bad), 32'd0);
    $display("conv %s: value=%0d -> %0d%0d%0d%0d ovf=%0d latency=%0d", tag, v,
             bus.thousands, bus.hundreds, bus.tens, bus.ones, bus.overflow, lat);
  endtask

  task automatic check_done_cleared(input string tag);
    tick();
    check({tag, " done single"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    logic [31:0] held_val;
    errors = 0;
    checks = 0;
    bus.start  = 1'b0;
    bus.binary = '0;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check_digits("rst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    reset = 1'b0;
    tick();

    // Basic conversion and boundaries
    convert("1234", 32'd1234);
    check_digits("1234", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    check_done_cleared("1234");

    convert("0", 32'd0);
    check_digits("0", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    check_done_cleared("0");

    convert("9999", 32'd9999);
    check_digits("9999", 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    check_done_cleared("9999");

    convert("10000", 32'd10000);
    check_digits("10000", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check_done_cleared("10000");

    convert("max", 32'hFFFF_FFFF);
    check_digits("max", 4'd7, 4'd2, 4'd9, 4'd5, 1'b1);
    check_done_cleared("max");

    convert("4321", 32'd4321);
    check_digits("4321", 4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    check_done_cleared("4321");

    // start held high while binary changes every cycle
    bus.binary = 32'd111;
    bus.start  = 1'b1;
    tick();
    check("held accept busy", 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      bus.binary = $urandom;
      check_digits_hold: begin end
      tick();
      lat++;
    end
    check("held latency", 32'(lat), 32'd33);
    check_digits("held first", 4'd0, 4'd1, 4'd1, 4'd1, 1'b0);
    held_val = 32'd5678;
    bus.binary = held_val;
    tick();
    check("held reaccept busy", 32'(bus.busy), 32'd1);
    check("held reaccept done", 32'(bus.done), 32'd0);
    bus.start  = 1'b0;
    bus.binary = 32'd0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("held second latency", 32'(lat), 32'd33);
    check_digits("held second", 4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
    check_done_cleared("held second");

    // Reset in the middle of a shift sequence
    bus.binary = 32'd8765;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check("midrst busy before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check_digits("midrst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) lat++;
    end
    check("midrst no activity", 32'(lat), 32'd0);
    convert("post rst", 32'd1234);
    check_digits("post rst", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    check_done_cleared("post rst");

    // Random sweep against a decimal reference model
    for (int i = 0; i < 500; i++) begin
      v = (i % 2 == 0) ? 32'($urandom_range(0, 20000)) : $urandom;
      convert("rand", v);
      check_digits("rand", 4'((v / 1000) % 10), 4'((v / 100) % 10),
                   4'((v / 10) % 10), 4'(v % 10), (v > 32'd9999));
      check_done_cleared("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
